// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one outstanding single-beat command -> AW/W+B or AR+R, response held until rsp_ready.
// Accept-to-VALID 1 cycle; cmd_ready only in IDLE. Optional watchdog under AXI_LITE_MASTER_TIMEOUT_EN.
module axi_lite_master #(
   parameter int REG_WIDTH      = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [REG_WIDTH-1:0]    cmd_wdata,
   input  logic [REG_WIDTH/8-1:0]  cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic [REG_WIDTH-1:0]    rsp_rdata,
   output logic [1:0]              rsp_resp,
`ifdef AXI_LITE_MASTER_TIMEOUT_EN
   output logic                    timeout_o,
`endif
   output logic [ADDR_WIDTH-1:0]   AWADDR,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   output logic [REG_WIDTH-1:0]    WDATA,
   output logic [REG_WIDTH/8-1:0]  WSTRB,
   output logic                    WVALID,
   input  logic                    WREADY,
   input  logic                    BVALID,
   output logic                    BREADY,
   input  logic [1:0]              BRESP,
   output logic [ADDR_WIDTH-1:0]   ARADDR,
   output logic                    ARVALID,
   input  logic                    ARREADY,
   input  logic [REG_WIDTH-1:0]    RDATA,
   input  logic                    RVALID,
   output logic                    RREADY,
   input  logic [1:0]              RRESP
);

   localparam int STRB_W = REG_WIDTH / 8;

   if (((REG_WIDTH % 8) != 0) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
      $error("axi_lite_master: REG_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_REQ,
      S_WR_RESP,
      S_RD_REQ,
      S_RD_DATA,
      S_RSP
   } state_t;

   state_t                  state;
   state_t                  state_nxt;

   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [REG_WIDTH-1:0]    wdata_q;
   logic [STRB_W-1:0]       wstrb_q;
   logic                    aw_done;
   logic                    w_done;
   logic                    rsp_write_q;
   logic [REG_WIDTH-1:0]    rsp_rdata_q;
   logic [1:0]              rsp_resp_q;

   logic                    cmd_fire;
   logic                    aw_fire;
   logic                    w_fire;
   logic                    b_fire;
   logic                    ar_fire;
   logic                    r_fire;
   logic                    tmo;

   // All VALID/READY outputs decode from registered state only, never from slave READY.
   assign cmd_ready = (state == S_IDLE) && !ARESET;
   assign AWVALID   = (state == S_WR_REQ) && !aw_done;
   assign WVALID    = (state == S_WR_REQ) && !w_done;
   assign BREADY    = (state == S_WR_RESP);
   assign ARVALID   = (state == S_RD_REQ);
   assign RREADY    = (state == S_RD_DATA);
   assign rsp_valid = (state == S_RSP);

   assign AWADDR    = addr_q;
   assign ARADDR    = addr_q;
   assign WDATA     = wdata_q;
   assign WSTRB     = wstrb_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;

   assign cmd_fire  = cmd_valid && cmd_ready;
   assign aw_fire   = AWVALID && AWREADY;
   assign w_fire    = WVALID && WREADY;
   assign b_fire    = BVALID && BREADY;
   assign ar_fire   = ARVALID && ARREADY;
   assign r_fire    = RVALID && RREADY;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tmo_cnt;
   logic          waiting;
   logic          progress;

   assign waiting   = (state == S_WR_REQ) || (state == S_WR_RESP) ||
                      (state == S_RD_REQ) || (state == S_RD_DATA);
   assign progress  = aw_fire || w_fire || b_fire || ar_fire || r_fire;
   assign tmo       = waiting && !progress && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign timeout_o = tmo;

   // Counts cycles spent waiting on the slave since the last handshake.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         tmo_cnt <= '0;
      end else if (cmd_fire || progress || !waiting) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (cmd_fire) begin
               state_nxt = cmd_write ? S_WR_REQ : S_RD_REQ;
            end
         end
         S_WR_REQ: begin
            if (tmo) begin
               state_nxt = S_RSP;
            end else if ((aw_done || aw_fire) && (w_done || w_fire)) begin
               state_nxt = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            if (tmo || b_fire) begin
               state_nxt = S_RSP;
            end
         end
         S_RD_REQ: begin
            if (tmo) begin
               state_nxt = S_RSP;
            end else if (ar_fire) begin
               state_nxt = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (tmo || r_fire) begin
               state_nxt = S_RSP;
            end
         end
         S_RSP: begin
            if (rsp_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state       <= S_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= 2'b00;
      end else begin
         state <= state_nxt;
         if (cmd_fire) begin
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_write ? cmd_wdata : '0;
            wstrb_q     <= cmd_write ? cmd_wstrb : '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_write_q <= cmd_write;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
         end
         if (aw_fire) begin
            aw_done <= 1'b1;
         end
         if (w_fire) begin
            w_done <= 1'b1;
         end
         if (b_fire) begin
            rsp_resp_q <= BRESP;
         end
         if (r_fire) begin
            rsp_rdata_q <= RDATA;
            rsp_resp_q  <= RRESP;
         end
         // A watchdog expiry reports SLVERR with no data.
         if (tmo) begin
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b10;
         end
      end
   end

endmodule
